// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier: one partial product per clock, with a start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module multiplicador_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk_100M,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    c_q, c_d;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is correct as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? WIDTH'(~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? WIDTH'(~b + 1'b1) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    // NOTE: every _d defaults to its _q before the case, so no path can infer a latch.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
`ifdef MULT_SIGNED_EN
    sign_d   = sign_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
`ifdef MULT_SIGNED_EN
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end

      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // The last iteration publishes the sum including its own partial product.
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
`ifdef MULT_SIGNED_EN
          c_d     = sign_q ? PW'(~acc_sum + 1'b1) : acc_sum;
`else
          c_d     = acc_sum;
`endif
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop updates from the pre-edge values of the others.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
`ifdef MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == FIN);
  assign c    = c_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq: WIDTH=4 vector table plus WIDTH=8 instance,
// hand sequences for start-during-CALC, mid-CALC reset and back-to-back starts.
module tb_multiplicador_seq;

  logic        clk_100M = 1'b0;
  logic        rst      = 1'b1;
  logic        start4   = 1'b0;
  logic        start8   = 1'b0;
  logic [3:0]  a4       = '0;
  logic [3:0]  b4       = '0;
  logic [7:0]  a8       = '0;
  logic [7:0]  b8       = '0;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  c4;
  logic [15:0] c8;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  prev_c4 = '0;
  logic [15:0] prev_c8 = '0;

  always #5 clk_100M = ~clk_100M;

  multiplicador_seq #(.WIDTH(4)) u_dut4 (
    .clk_100M (clk_100M),
    .rst      (rst),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .busy     (busy4),
    .done     (done4),
    .c        (c4)
  );

  multiplicador_seq #(.WIDTH(8)) u_dut8 (
    .clk_100M (clk_100M),
    .rst      (rst),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .c        (c8)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one multiply and check every cycle of the handshake; glitch>0 pulses
  // start with a=1,b=1 at that CALC cycle, which must be ignored.
  task automatic run_op(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input int glitch);
    int lat;
    lat = wide ? 8 : 4;
    @(negedge clk_100M);
    check("idle_busy", wide ? busy8 : busy4, 1'b0);
    check("idle_done", wide ? done8 : done4, 1'b0);
    if (wide) begin
      start8 = 1'b1; a8 = av; b8 = bv;
    end else begin
      start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_100M);
      check("calc_busy", wide ? busy8 : busy4, 1'b1);
      check("calc_done", wide ? done8 : done4, 1'b0);
      check("calc_c_hold", wide ? c8 : {8'h00, c4}, wide ? prev_c8 : {8'h00, prev_c4});
      if (k == glitch) begin
        start4 = 1'b1; a4 = 4'h1; b4 = 4'h1;
        start8 = 1'b0;
      end else begin
        start4 = 1'b0; start8 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    @(negedge clk_100M);
    start4 = 1'b0; start8 = 1'b0;
    check("fin_done", wide ? done8 : done4, 1'b1);
    check("fin_busy", wide ? busy8 : busy4, 1'b0);
    check("fin_c", wide ? c8 : {8'h00, c4}, exp);
    if (wide) prev_c8 = exp;
    else      prev_c4 = exp[7:0];
  endtask

  initial begin
`ifdef MULT_SIGNED_EN
    tbl[0] = '{4'h8, 4'h7, 8'hC8};  // -8 * 7  = -56
    tbl[1] = '{4'h8, 4'h8, 8'h40};  // -8 * -8 = 64
    tbl[2] = '{4'hF, 4'h1, 8'hFF};  // -1 * 1  = -1
    tbl[3] = '{4'h3, 4'h3, 8'h09};
    tbl[4] = '{4'h7, 4'hF, 8'hF9};  //  7 * -1 = -7
    tbl[5] = '{4'h0, 4'hB, 8'h00};
    tbl[6] = '{4'h5, 4'hD, 8'hF1};  //  5 * -3 = -15
    tbl[7] = '{4'hF, 4'hF, 8'h01};
`else
    tbl[0] = '{4'h3, 4'h3, 8'h09};
    tbl[1] = '{4'hF, 4'hF, 8'hE1};
    tbl[2] = '{4'h0, 4'h7, 8'h00};
    tbl[3] = '{4'h5, 4'h6, 8'h1E};
    tbl[4] = '{4'h1, 4'hF, 8'h0F};
    tbl[5] = '{4'hC, 4'hA, 8'h78};
    tbl[6] = '{4'h8, 4'h8, 8'h40};
    tbl[7] = '{4'hF, 4'h1, 8'h0F};
`endif

    // Reset state
    repeat (2) @(negedge clk_100M);
    check("rst_c4", c4, 8'h00);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_c8", c8, 16'h0000);
    check("rst_busy8", busy8, 1'b0);
    rst = 1'b0;

    // Vector table, issued back-to-back at the earliest legal edge
    for (int i = 0; i < 8; i++)
      run_op(1'b0, {4'h0, tbl[i].a}, {4'h0, tbl[i].b}, {8'h00, tbl[i].c}, 0);

    // start pulsed two cycles into CALC must be ignored
    run_op(1'b0, 8'd7, 8'd7, 16'd49, 2);
    @(negedge clk_100M);
    check("glitch_no_restart_busy", busy4, 1'b0);
    check("glitch_single_done", done4, 1'b0);

    // Reset mid-CALC aborts: c cleared, no done pulse afterwards
    @(negedge clk_100M);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    @(negedge clk_100M);
    start4 = 1'b0;
    @(negedge clk_100M);
    check("pre_abort_busy", busy4, 1'b1);
    rst = 1'b1;
    @(negedge clk_100M);
    rst = 1'b0;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_c4", c4, 8'h00);
    check("abort_c8", c8, 16'h0000);
    prev_c4 = '0;
    prev_c8 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_100M);
      check("abort_no_done", done4, 1'b0);
    end
    run_op(1'b0, 8'd4, 8'd3, 16'd12, 0);

    // WIDTH=8 instance, back-to-back
`ifdef MULT_SIGNED_EN
    run_op(1'b1, 8'd255, 8'd255, 16'h0001, 0);
`else
    run_op(1'b1, 8'd255, 8'd255, 16'hFE01, 0);
`endif
    run_op(1'b1, 8'd16, 8'd16, 16'h0100, 0);
    @(negedge clk_100M);
    check("w8_idle_after", busy8, 1'b0);
    check("w8_c_hold", c8, 16'h0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
